jelly2_video_size_parameter_ex: RTL and testbench
=================================================

# jelly2_video_size_parameter_ex

Single-clock, register-controlled video stream stage that attaches frame size (x/y) to an AXI4-Stream video stream, with parameter shadowing applied only at frame start. Adds a measured-size mode, frame-boundary enable gating, a frame counter, and sticky geometry-error flags. Sits between a video source and any downstream block that needs per-frame size sideband. Wishbone registers and the stream share one clock.

## Interface
- TUSER_WIDTH, 1, stream tuser width; bit0 = frame start
- TDATA_WIDTH, 24, pixel data width
- X_WIDTH, 14, x size/counter width
- Y_WIDTH, 12, y size/counter width
- FRAME_COUNT_WIDTH, 32, frame counter width
- INDEX_WIDTH, 1, update index width
- WB_ADR_WIDTH, 8 / WB_DAT_WIDTH, 32 / WB_SEL_WIDTH, WB_DAT_WIDTH/8, Wishbone widths
- CORE_ID, 32'h527A1231; CORE_VERSION, 32'h00000000
- INIT_CTL_CONTROL, 3'b011; INIT_PARAM_MODE, 1'b0; INIT_PARAM_X_SIZE, 0; INIT_PARAM_Y_SIZE, 0
- Reset is aresetn, synchronous, active-low; clock is s_wb_clk_i.

Ports:
- s_wb_clk_i  in  1  clock (stream and registers)
- aresetn  in  1  synchronous active-low reset
- in_update_req  in  1  external update request pulse
- s_axi4s_tuser/tlast/tdata/tvalid  in  TUSER_WIDTH/1/TDATA_WIDTH/1; s_axi4s_tready  out  1
- m_axi4s_x_size  out  X_WIDTH; m_axi4s_y_size  out  Y_WIDTH
- m_axi4s_tuser/tlast/tdata/tvalid  out; m_axi4s_tready  in  1
- s_wb_adr_i, s_wb_dat_i, s_wb_dat_o, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_ack_o: standard Wishbone slave

## Operation
- Register map (word address): 0x00 CORE_ID (RO), 0x01 CORE_VERSION (RO), 0x04 CTL_CONTROL (bit0 enable, bit1 update request, bit2 auto-update), 0x05 CTL_STATUS (RO: bit0 active enable, bit1 in-frame), 0x07 CTL_INDEX (RO), 0x08 PARAM_MODE (0 = register sizes, 1 = measured), 0x10 PARAM_X_SIZE, 0x11 PARAM_Y_SIZE, 0x20 MON_X_SIZE (RO), 0x21 MON_Y_SIZE (RO), 0x22 MON_FRAME_COUNT (RO), 0x23 MON_ERROR (write-1-to-clear; bit0 line-length mismatch, bit1 counter overflow). Writes honour byte select. Unmapped reads return 0. s_wb_ack_o = s_wb_stb_i.
- Frame start (fs) = tuser[0] & tvalid & tready.
- Pending update = CTL_CONTROL[1] | latched in_update_req (latch set on pulse). On fs with update pending: shadow enable, mode, x, y are loaded; ctl_index increments (wraps); in_update_req latch clears; CTL_CONTROL[1] clears unless bit2 is set.
- Enable gating: the shadow enable changes only at fs. While the shadow enable is 0, input beats are accepted (tready = 1) and dropped; no partial frames are emitted.
- Measurement: x counter counts beats per line; y counter counts tlast beats. At each fs: MON_X_SIZE = length of the first line of the previous frame, MON_Y_SIZE = its line count; MON_FRAME_COUNT increments (wraps). The first fs after reset loads 0/0.
- Any line whose length differs from the frame's first line sets ERROR bit0. A counter that reaches all-ones saturates and sets ERROR bit1.
- Size output: in mode 0, the shadow x/y; in mode 1, the MON values captured at that fs.
- Simultaneous events: a Wishbone write to CTL_CONTROL in the same cycle as the auto-clear wins. in_update_req coincident with fs applies at that fs. An ERROR W1C coincident with a new error leaves the bit set.

## Timing
- Output register slice, 1-cycle latency. s_axi4s_tready = m_axi4s_tready | ~out_valid (or 1 while disabled).
- Sizes and output enable update on the cycle after the fs beat is accepted, aligned with that beat's appearance on m_axi4s.
- Reset values: m_axi4s_tvalid 0; tuser/tlast/tdata 0; x/y sizes INIT_PARAM_*; shadow enable INIT_CTL_CONTROL[0]; counters, MON, ERROR and index 0.
- Reset mid-frame: output drops immediately; the next output begins only at a new fs.

## Test plan
- Mode 0, x=640, y=480, enable: 640×480 frame in -> identical beats out 1 cycle later, m_x_size=640, m_y_size=480, tvalid never 0 under tready=1.
- Write X=320 mid-frame plus CTL_CONTROL=3 -> sizes stay 640 until the next fs, then 320; CTL_CONTROL reads 1; CTL_INDEX toggles.
- Mode 1, send a 100×50 frame then an fs -> MON_X=100, MON_Y=50, m_x_size=100, MON_FRAME_COUNT=2.
- Frame with line 3 of length 99 -> ERROR=1; write 1 to 0x23 -> reads 0.
- Clear enable mid-frame with update -> current frame completes; next frame consumed with tready=1 and m_axi4s_tvalid=0.
- Random m_axi4s_tready backpressure -> no beat lost or duplicated; aresetn low mid-frame -> tvalid 0 next cycle.

Source files
------------

// File: rtl/jelly2_video_size_parameter_ex.sv
// Video stream stage that tags each beat with the frame x/y size. Wishbone
// parameters are shadowed at frame start; sizes may also be measured from the stream.
module jelly2_video_size_parameter_ex #(
    parameter int unsigned               TUSER_WIDTH       = 1,
    parameter int unsigned               TDATA_WIDTH       = 24,
    parameter int unsigned               X_WIDTH           = 14,
    parameter int unsigned               Y_WIDTH           = 12,
    parameter int unsigned               FRAME_COUNT_WIDTH = 32,
    parameter int unsigned               INDEX_WIDTH       = 1,
    parameter int unsigned               WB_ADR_WIDTH      = 8,
    parameter int unsigned               WB_DAT_WIDTH      = 32,
    parameter int unsigned               WB_SEL_WIDTH      = WB_DAT_WIDTH / 8,
    parameter logic [WB_DAT_WIDTH-1:0]   CORE_ID           = 32'h527A1231,
    parameter logic [WB_DAT_WIDTH-1:0]   CORE_VERSION      = 32'h00000000,
    parameter logic [2:0]                INIT_CTL_CONTROL  = 3'b011,
    parameter logic                      INIT_PARAM_MODE   = 1'b0,
    parameter logic [X_WIDTH-1:0]        INIT_PARAM_X_SIZE = '0,
    parameter logic [Y_WIDTH-1:0]        INIT_PARAM_Y_SIZE = '0
) (
    input  logic                     s_wb_clk_i,
    input  logic                     aresetn,
    input  logic                     in_update_req,

    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,

    output logic [X_WIDTH-1:0]       m_axi4s_x_size,
    output logic [Y_WIDTH-1:0]       m_axi4s_y_size,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready,

    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    input  logic                     s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o
);
    localparam logic [X_WIDTH-1:0] X_MAX = '1;
    localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

    localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID      = WB_ADR_WIDTH'(8'h00);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_VERSION = WB_ADR_WIDTH'(8'h01);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_CONTROL  = WB_ADR_WIDTH'(8'h04);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_STATUS   = WB_ADR_WIDTH'(8'h05);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_INDEX    = WB_ADR_WIDTH'(8'h07);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_MODE   = WB_ADR_WIDTH'(8'h08);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_X_SIZE = WB_ADR_WIDTH'(8'h10);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_Y_SIZE = WB_ADR_WIDTH'(8'h11);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_MON_X_SIZE   = WB_ADR_WIDTH'(8'h20);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_MON_Y_SIZE   = WB_ADR_WIDTH'(8'h21);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_MON_FRAME    = WB_ADR_WIDTH'(8'h22);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_MON_ERROR    = WB_ADR_WIDTH'(8'h23);

    function automatic logic [WB_DAT_WIDTH-1:0] wb_mask(
        input logic [WB_DAT_WIDTH-1:0] cur,
        input logic [WB_DAT_WIDTH-1:0] dat,
        input logic [WB_SEL_WIDTH-1:0] sel
    );
        logic [WB_DAT_WIDTH-1:0] res;
        for (int i = 0; i < WB_SEL_WIDTH; i++) begin
            res[i*8 +: 8] = sel[i] ? dat[i*8 +: 8] : cur[i*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [X_WIDTH-1:0] sat_inc_x(input logic [X_WIDTH-1:0] v);
        return (v == X_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [Y_WIDTH-1:0] sat_inc_y(input logic [Y_WIDTH-1:0] v);
        return (v == Y_MAX) ? v : v + 1'b1;
    endfunction

    logic [2:0]                   ctl_q, ctl_d;
    logic                         mode_q, mode_d, smode_q, smode_d;
    logic [X_WIDTH-1:0]           px_q, px_d, sx_q, sx_d;
    logic [Y_WIDTH-1:0]           py_q, py_d, sy_q, sy_d;
    logic                         upd_req_q, upd_req_d, en_q, en_d, in_frame_q, in_frame_d;
    logic [INDEX_WIDTH-1:0]       idx_q, idx_d;
    logic [1:0]                   err_q, err_d, err_set, err_clr;
    logic [X_WIDTH-1:0]           xcnt_q, first_x_q, mon_x_q, x_size_q, xcur, xlen;
    logic [Y_WIDTH-1:0]           ycnt_q, mon_y_q, y_size_q, ycur, ylen;
    logic [FRAME_COUNT_WIDTH-1:0] fcnt_q;
    logic                         ov_q, ol_q;
    logic [TUSER_WIDTH-1:0]       ou_q;
    logic [TDATA_WIDTH-1:0]       od_q;

    logic pending, out_ready, acc, fs, load, en_eff, active, meas, emit, wr;

    // An enabling frame start must wait for the output slice; dropped beats never do.
    assign pending        = ctl_q[1] | upd_req_q | in_update_req;
    assign out_ready      = m_axi4s_tready | ~ov_q;
    assign s_axi4s_tready = out_ready | (~en_q & ~(s_axi4s_tuser[0] & pending));
    assign acc            = s_axi4s_tvalid & s_axi4s_tready;
    assign fs             = acc & s_axi4s_tuser[0];
    assign load           = fs & pending;
    assign en_eff         = load ? ctl_q[0] : en_q;
    assign active         = fs | in_frame_q;
    assign meas           = acc & active;
    assign emit           = acc & en_eff & active;
    assign wr             = s_wb_stb_i & s_wb_we_i;

    always_comb begin
        xcur       = fs ? '0 : xcnt_q;
        ycur       = fs ? '0 : ycnt_q;
        xlen       = sat_inc_x(xcur);
        ylen       = sat_inc_y(ycur);
        err_set    = '0;
        err_set[0] = meas & s_axi4s_tlast & (ycur != '0) & (xlen != first_x_q);
        err_set[1] = meas & ((xlen == X_MAX) | (s_axi4s_tlast & (ylen == Y_MAX)));
        err_clr    = (wr && s_wb_adr_i == ADR_MON_ERROR) ? 2'(wb_mask('0, s_wb_dat_i, s_wb_sel_i)) : '0;
    end

    always_comb begin
        ctl_d      = ctl_q;
        mode_d     = mode_q;
        px_d       = px_q;
        py_d       = py_q;
        upd_req_d  = upd_req_q | in_update_req;
        en_d       = en_q;
        smode_d    = smode_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        idx_d      = idx_q;
        in_frame_d = in_frame_q | fs;
        err_d      = (err_q & ~err_clr) | err_set;
        if (load) begin
            en_d      = ctl_q[0];
            smode_d   = mode_q;
            sx_d      = px_q;
            sy_d      = py_q;
            idx_d     = idx_q + 1'b1;
            upd_req_d = 1'b0;
            if (!ctl_q[2]) ctl_d[1] = 1'b0;
        end
        // Register writes come last so a host write beats the auto-clear.
        if (wr) begin
            case (s_wb_adr_i)
                ADR_CTL_CONTROL:  ctl_d  = 3'(wb_mask(WB_DAT_WIDTH'(ctl_q), s_wb_dat_i, s_wb_sel_i));
                ADR_PARAM_MODE:   mode_d = 1'(wb_mask(WB_DAT_WIDTH'(mode_q), s_wb_dat_i, s_wb_sel_i));
                ADR_PARAM_X_SIZE: px_d   = X_WIDTH'(wb_mask(WB_DAT_WIDTH'(px_q), s_wb_dat_i, s_wb_sel_i));
                ADR_PARAM_Y_SIZE: py_d   = Y_WIDTH'(wb_mask(WB_DAT_WIDTH'(py_q), s_wb_dat_i, s_wb_sel_i));
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_wb_clk_i) begin
        if (!aresetn) begin
            ctl_q <= INIT_CTL_CONTROL;   mode_q <= INIT_PARAM_MODE;
            px_q  <= INIT_PARAM_X_SIZE;  py_q   <= INIT_PARAM_Y_SIZE;
            en_q  <= INIT_CTL_CONTROL[0]; smode_q <= INIT_PARAM_MODE;
            sx_q  <= INIT_PARAM_X_SIZE;  sy_q   <= INIT_PARAM_Y_SIZE;
            upd_req_q <= 1'b0; in_frame_q <= 1'b0; idx_q <= '0; err_q <= '0;
            xcnt_q <= '0; ycnt_q <= '0; first_x_q <= '0;
            mon_x_q <= '0; mon_y_q <= '0; fcnt_q <= '0;
            x_size_q <= INIT_PARAM_X_SIZE; y_size_q <= INIT_PARAM_Y_SIZE;
            ov_q <= 1'b0; ou_q <= '0; ol_q <= 1'b0; od_q <= '0;
        end else begin
            ctl_q <= ctl_d;   mode_q <= mode_d;   px_q <= px_d;   py_q <= py_d;
            en_q  <= en_d;    smode_q <= smode_d; sx_q <= sx_d;   sy_q <= sy_d;
            upd_req_q <= upd_req_d; in_frame_q <= in_frame_d; idx_q <= idx_d; err_q <= err_d;
            if (meas) begin
                xcnt_q <= s_axi4s_tlast ? '0 : xlen;
                if (s_axi4s_tlast)  ycnt_q <= ylen;
                else if (fs)        ycnt_q <= '0;
                if (s_axi4s_tlast && ycur == '0) first_x_q <= xlen;
                else if (fs)                     first_x_q <= '0;
            end
            if (fs) begin
                mon_x_q  <= first_x_q;
                mon_y_q  <= ycnt_q;
                fcnt_q   <= fcnt_q + 1'b1;
                x_size_q <= (load ? mode_q : smode_q) ? first_x_q : (load ? px_q : sx_q);
                y_size_q <= (load ? mode_q : smode_q) ? ycnt_q    : (load ? py_q : sy_q);
            end
            if (out_ready) begin
                ov_q <= emit;
                if (emit) begin
                    ou_q <= s_axi4s_tuser;
                    ol_q <= s_axi4s_tlast;
                    od_q <= s_axi4s_tdata;
                end
            end
        end
    end

    assign m_axi4s_tvalid = ov_q;
    assign m_axi4s_tuser  = ou_q;
    assign m_axi4s_tlast  = ol_q;
    assign m_axi4s_tdata  = od_q;
    assign m_axi4s_x_size = x_size_q;
    assign m_axi4s_y_size = y_size_q;
    assign s_wb_ack_o     = s_wb_stb_i;

    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            ADR_CORE_ID:      s_wb_dat_o = CORE_ID;
            ADR_CORE_VERSION: s_wb_dat_o = CORE_VERSION;
            ADR_CTL_CONTROL:  s_wb_dat_o = WB_DAT_WIDTH'(ctl_q);
            ADR_CTL_STATUS:   s_wb_dat_o = WB_DAT_WIDTH'({in_frame_q, en_q});
            ADR_CTL_INDEX:    s_wb_dat_o = WB_DAT_WIDTH'(idx_q);
            ADR_PARAM_MODE:   s_wb_dat_o = WB_DAT_WIDTH'(mode_q);
            ADR_PARAM_X_SIZE: s_wb_dat_o = WB_DAT_WIDTH'(px_q);
            ADR_PARAM_Y_SIZE: s_wb_dat_o = WB_DAT_WIDTH'(py_q);
            ADR_MON_X_SIZE:   s_wb_dat_o = WB_DAT_WIDTH'(mon_x_q);
            ADR_MON_Y_SIZE:   s_wb_dat_o = WB_DAT_WIDTH'(mon_y_q);
            ADR_MON_FRAME:    s_wb_dat_o = WB_DAT_WIDTH'(fcnt_q);
            ADR_MON_ERROR:    s_wb_dat_o = WB_DAT_WIDTH'(err_q);
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jelly2_video_size_parameter_ex.sv
// Directed bench for jelly2_video_size_parameter_ex: register access, size shadowing,
// measured mode, error flags, enable gating, backpressure and mid-frame reset.
module tb_jelly2_video_size_parameter_ex;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn = 1'b0, in_update_req = 1'b0;
    logic [0:0]  s_tuser = '0;
    logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
    logic [23:0] s_tdata = '0;
    logic [13:0] m_x;
    logic [11:0] m_y;
    logic [0:0]  m_tuser;
    logic        m_tlast, m_tvalid, m_tready = 1'b1;
    logic [23:0] m_tdata;
    logic [7:0]  wb_adr = '0;
    logic [31:0] wb_dat_i = '0, wb_dat_o;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_ack;
    logic [3:0]  wb_sel = '0;

    jelly2_video_size_parameter_ex dut (
        .s_wb_clk_i(clk), .aresetn(aresetn), .in_update_req(in_update_req),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_x_size(m_x), .m_axi4s_y_size(m_y),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
        .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
        .s_wb_adr_i(wb_adr), .s_wb_dat_o(wb_dat_o), .s_wb_dat_i(wb_dat_i),
        .s_wb_we_i(wb_we), .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack)
    );

    int n_chk = 0, n_err = 0, stalls = 0, timeouts = 0, cyc = 0;
    bit bp_en = 1'b0;
    logic [51:0] exp_q[$], obs_q[$];
    int obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            obs_q.push_back({m_tuser, m_tlast, m_tdata, m_x, m_y});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_check(input string tag, input logic [7:0] adr, input logic [31:0] want);
        logic [31:0] got;
        wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1;
        @(negedge clk);
        got = wb_dat_o;
        check({tag, "_ack"}, 64'(wb_ack), 64'd1);
        @(posedge clk); #1;
        wb_stb = 1'b0;
        check(tag, 64'(got), 64'(want));
    endtask

    task automatic send(input logic u, input logic l, input logic [23:0] d);
        int t;
        t = 0;
        s_tuser = u; s_tlast = l; s_tdata = d; s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            t++; stalls++;
            @(negedge clk);
        end
        if (t >= 200) timeouts++;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int bad_line, input int bad_w,
                              input logic [23:0] base, input bit expect_out, input int xs, input int ys);
        int lw;
        logic u, l;
        logic [23:0] d;
        for (int y = 0; y < h; y++) begin
            lw = (y == bad_line) ? bad_w : w;
            for (int x = 0; x < lw; x++) begin
                u = (y == 0 && x == 0);
                l = (x == lw - 1);
                d = base + 24'(y * 256 + x);
                if (expect_out) exp_q.push_back({u, l, d, 14'(xs), 12'(ys)});
                send(u, l, d);
            end
        end
    endtask

    task automatic drain();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic cmp_stream(input string tag);
        int nbad, n;
        nbad = 0;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) nbad++;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        check({tag, "_beats"}, 64'(nbad), 64'd0);
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    initial begin
        int span;
        do_reset();
        // Reset state
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_xsize", 64'(m_x), 64'd0);
        check("rst_ysize", 64'(m_y), 64'd0);
        wb_check("core_id", 8'h00, 32'h527A1231);
        wb_check("core_ver", 8'h01, 32'h0);
        wb_check("rst_ctl", 8'h04, 32'h3);
        wb_check("rst_status", 8'h05, 32'h1);
        wb_check("rst_index", 8'h07, 32'h0);
        wb_check("rst_fcnt", 8'h22, 32'h0);
        wb_check("unmapped", 8'h3F, 32'h0);

        // Mode 0 with register sizes 640x480
        wb_write(8'h10, 32'd640);
        wb_write(8'h11, 32'd480);
        send_frame(8, 4, -1, 0, 24'h100000, 1'b1, 640, 480);
        drain();
        span = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] - obs_cyc[0] : -1;
        check("a_span", 64'(span), 64'd31);
        cmp_stream("a");
        wb_check("a_ctl", 8'h04, 32'h1);
        wb_check("a_index", 8'h07, 32'h1);
        wb_check("a_status", 8'h05, 32'h3);
        wb_write(8'h10, 32'hFFFF_FF55, 4'b0001);
        wb_check("bytesel_x", 8'h10, 32'h255);
        wb_write(8'h10, 32'd640);

        // Mid-frame parameter change applies at the next frame start only
        fork
            send_frame(8, 4, -1, 0, 24'h200000, 1'b1, 640, 480);
            begin
                repeat (10) @(posedge clk);
                #1;
                wb_write(8'h10, 32'd320);
                wb_write(8'h04, 32'h3);
            end
        join
        check("b_xsize_held", 64'(m_x), 64'd640);
        wb_check("b_ctl", 8'h04, 32'h3);
        send_frame(8, 4, -1, 0, 24'h300000, 1'b1, 320, 480);
        drain();
        cmp_stream("bc");
        wb_check("c_ctl", 8'h04, 32'h1);
        wb_check("c_index", 8'h07, 32'h0);
        wb_check("c_fcnt", 8'h22, 32'd3);
        wb_check("c_monx", 8'h20, 32'd8);

        // Measured mode: 100x50 frame then a 1x1 frame
        do_reset();
        wb_write(8'h08, 32'h1);
        send_frame(100, 50, -1, 0, 24'h400000, 1'b1, 0, 0);
        send_frame(1, 1, -1, 0, 24'h500000, 1'b1, 100, 50);
        drain();
        cmp_stream("de");
        wb_check("e_monx", 8'h20, 32'd100);
        wb_check("e_mony", 8'h21, 32'd50);
        wb_check("e_fcnt", 8'h22, 32'd2);
        wb_check("e_error", 8'h23, 32'h0);

        // Short line sets the line-length error; W1C honours byte select
        send_frame(10, 4, 2, 9, 24'h600000, 1'b1, 1, 1);
        drain();
        cmp_stream("f");
        wb_check("f_error", 8'h23, 32'h1);
        wb_write(8'h23, 32'h1, 4'b0000);
        wb_check("f_error_nosel", 8'h23, 32'h1);
        wb_write(8'h23, 32'h1);
        wb_check("f_error_clr", 8'h23, 32'h0);

        // Disable mid-frame: current frame completes, next one is dropped
        fork
            send_frame(6, 3, -1, 0, 24'h700000, 1'b1, 10, 4);
            begin
                repeat (5) @(posedge clk);
                #1;
                wb_write(8'h04, 32'h2);
            end
        join
        stalls = 0;
        send_frame(6, 3, -1, 0, 24'h800000, 1'b0, 0, 0);
        drain();
        check("i_stalls", 64'(stalls), 64'd0);
        cmp_stream("hi");
        wb_check("i_ctl", 8'h04, 32'h0);
        wb_check("i_status", 8'h05, 32'h2);
        wb_check("i_index", 8'h07, 32'h0);
        wb_check("i_fcnt", 8'h22, 32'd5);

        // Re-enable under random backpressure
        wb_write(8'h08, 32'h0);
        wb_write(8'h10, 32'd12);
        wb_write(8'h11, 32'd6);
        wb_write(8'h04, 32'h3);
        bp_en = 1'b1;
        send_frame(12, 6, -1, 0, 24'h900000, 1'b1, 12, 6);
        bp_en = 1'b0;
        drain();
        cmp_stream("j_bp");

        // External update pulse, then auto-update keeps bit1 set
        wb_write(8'h10, 32'd20);
        in_update_req = 1'b1;
        @(posedge clk); #1;
        in_update_req = 1'b0;
        send_frame(4, 2, -1, 0, 24'hA00000, 1'b1, 20, 6);
        wb_write(8'h04, 32'h7);
        wb_write(8'h11, 32'd9);
        send_frame(4, 2, -1, 0, 24'hB00000, 1'b1, 20, 9);
        drain();
        cmp_stream("mn");
        wb_check("n_ctl", 8'h04, 32'h7);
        wb_check("n_index", 8'h07, 32'h1);

        // Reset mid-frame: output drops, resumes only at a new frame start
        send(1'b1, 1'b0, 24'hC00000);
        for (int i = 1; i < 5; i++) send(1'b0, 1'b0, 24'hC00000 + 24'(i));
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("k_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("k_rst_xsize", 64'(m_x), 64'd0);
        @(posedge clk); #1;
        obs_q.delete(); exp_q.delete(); obs_cyc.delete();
        for (int i = 5; i < 8; i++) send(1'b0, (i == 7), 24'hC00000 + 24'(i));
        for (int i = 0; i < 8; i++) send(1'b0, (i == 7), 24'hC00100 + 24'(i));
        send_frame(4, 2, -1, 0, 24'hD00000, 1'b1, 0, 0);
        drain();
        cmp_stream("kl");

        check("timeouts", 64'(timeouts), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
